lsu_lsq_ooo: RTL and testbench

Parametrised load/store queue between the LSU address stage (AGU/AC) and the non-blocking dcache. Allocates entries in program order and issues requests to the dcache in order. Accepts load responses out of order by tag and retires to the ROB strictly in order, one per cycle. Flush recovery drains in-flight loads before new allocation is accepted.

---
 rtl/lsu_lsq_ooo_pkg.sv | 24 ++
 rtl/lsu_lsq_ooo_if.sv | 32 +++
 rtl/lsu_lsq_ooo_entry_array.sv | 112 +++++++++++
 rtl/lsu_lsq_ooo.sv | 185 ++++++++++++++++++
 tb/tb_lsu_lsq_ooo.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_lsq_ooo_pkg.sv
// Shared encodings and defaults for the load/store queue.
// Optional build macro: LSQ_PERF_CNT_EN enables the retire/full performance counters.
package lsu_lsq_ooo_pkg;

  localparam logic [1:0] ST_FREE       = 2'd0;
  localparam logic [1:0] ST_WAIT_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT_RESP  = 2'd2;
  localparam logic [1:0] ST_DONE       = 2'd3;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  localparam int LSQ_DEPTH     = 8;
  localparam int LSQ_XLEN      = 64;
  localparam int LSQ_ADDR_W    = 39;
  localparam int LSQ_ROB_IDX_W = 6;
  localparam int LSQ_PREG_W    = 6;
  localparam int LSQ_ECAUSE_W  = 4;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/lsu_lsq_ooo_if.sv
// Dcache request/response channel between the load/store queue and the non-blocking dcache.
interface lsu_lsq_ooo_if #(
  parameter int DEPTH  = 8,
  parameter int XLEN   = 64,
  parameter int ADDR_W = 39
);
  localparam int TAG_W = $clog2(DEPTH);

  logic              req_valid;
  logic              req_ready;
  logic              req_opcode;
  logic              req_sign;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_data;
  logic [TAG_W-1:0]  req_tag;
  logic              resp_valid;
  logic [TAG_W-1:0]  resp_tag;
  logic [XLEN-1:0]   resp_data;
  logic              resp_ready;

  modport master (
    output req_valid, req_opcode, req_sign, req_size, req_addr, req_data, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_tag, resp_data
  );

  modport slave (
    input  req_valid, req_opcode, req_sign, req_size, req_addr, req_data, req_tag, resp_ready,
    output req_ready, resp_valid, resp_tag, resp_data
  );

endinterface

// File: rtl/lsu_lsq_ooo_entry_array.sv
// Per-entry storage and state registers of the load/store queue, with alloc, issue,
// response and retire write ports and read views at the issue and head slots.
module lsq_entry_array
  import lsu_lsq_ooo_pkg::*;
#(
  parameter int DEPTH     = LSQ_DEPTH,
  parameter int XLEN      = LSQ_XLEN,
  parameter int ADDR_W    = LSQ_ADDR_W,
  parameter int ROB_IDX_W = LSQ_ROB_IDX_W,
  parameter int PREG_W    = LSQ_PREG_W,
  parameter int ECAUSE_W  = LSQ_ECAUSE_W,
  parameter int TAG_W     = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       alloc_en,
  input  logic [TAG_W-1:0]           alloc_idx,
  input  logic                       alloc_opcode,
  input  logic                       alloc_sign,
  input  logic [1:0]                 alloc_size,
  input  logic [ADDR_W-1:0]          alloc_addr,
  input  logic [XLEN-1:0]            alloc_data,
  input  logic [ROB_IDX_W-1:0]       alloc_rob,
  input  logic [PREG_W-1:0]          alloc_rd,
  input  logic                       alloc_exc,
  input  logic [ECAUSE_W-1:0]        alloc_ecause,
  input  logic                       issue_en,
  input  logic [TAG_W-1:0]           issue_idx,
  input  logic                       resp_en,
  input  logic [TAG_W-1:0]           resp_idx,
  input  logic [XLEN-1:0]            resp_data,
  input  logic                       retire_en,
  input  logic [TAG_W-1:0]           head_idx,
  output logic [DEPTH-1:0][1:0]      state,
  output logic                       iss_opcode,
  output logic                       iss_sign,
  output logic [1:0]                 iss_size,
  output logic [ADDR_W-1:0]          iss_addr,
  output logic [XLEN-1:0]            iss_data,
  output logic                       hd_opcode,
  output logic                       hd_exc,
  output logic [XLEN-1:0]            hd_data,
  output logic [ROB_IDX_W-1:0]       hd_rob,
  output logic [PREG_W-1:0]          hd_rd,
  output logic [ECAUSE_W-1:0]        hd_ecause
);

  logic [DEPTH-1:0][1:0] state_q;
  logic                  opcode_q [DEPTH];
  logic                  sign_q   [DEPTH];
  logic [1:0]            size_q   [DEPTH];
  logic [ADDR_W-1:0]     addr_q   [DEPTH];
  logic [XLEN-1:0]       data_q   [DEPTH];
  logic [ROB_IDX_W-1:0]  rob_q    [DEPTH];
  logic [PREG_W-1:0]     rd_q     [DEPTH];
  logic                  exc_q    [DEPTH];
  logic [ECAUSE_W-1:0]   ecause_q [DEPTH];

  // Each write port only ever targets a slot in one specific state, so at most one fires per slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush)
          state_q[i] <= ST_FREE;
        else if (alloc_en && alloc_idx == TAG_W'(i))
          state_q[i] <= alloc_exc ? ST_DONE : ST_WAIT_ISSUE;
        else if (issue_en && issue_idx == TAG_W'(i))
          state_q[i] <= (opcode_q[i] == OP_STORE) ? ST_DONE : ST_WAIT_RESP;
        else if (resp_en && resp_idx == TAG_W'(i))
          state_q[i] <= ST_DONE;
        else if (retire_en && head_idx == TAG_W'(i))
          state_q[i] <= ST_FREE;
      end
    end
  end

  // Payload needs no reset: it is only observed while the slot's state says it is live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_en && alloc_idx == TAG_W'(i)) begin
        opcode_q[i] <= alloc_opcode;
        sign_q[i]   <= alloc_sign;
        size_q[i]   <= alloc_size;
        addr_q[i]   <= alloc_addr;
        data_q[i]   <= alloc_data;
        rob_q[i]    <= alloc_rob;
        rd_q[i]     <= alloc_rd;
        exc_q[i]    <= alloc_exc;
        ecause_q[i] <= alloc_ecause;
      end else if (resp_en && resp_idx == TAG_W'(i)) begin
        data_q[i]   <= resp_data;
      end
    end
  end

  assign state      = state_q;
  assign iss_opcode = opcode_q[issue_idx];
  assign iss_sign   = sign_q[issue_idx];
  assign iss_size   = size_q[issue_idx];
  assign iss_addr   = addr_q[issue_idx];
  assign iss_data   = data_q[issue_idx];
  assign hd_opcode  = opcode_q[head_idx];
  assign hd_exc     = exc_q[head_idx];
  assign hd_data    = data_q[head_idx];
  assign hd_rob     = rob_q[head_idx];
  assign hd_rd      = rd_q[head_idx];
  assign hd_ecause  = ecause_q[head_idx];

endmodule

// File: rtl/lsu_lsq_ooo.sv
// Load/store queue: in-order alloc and dcache issue, out-of-order load responses, in-order retire.
// Optional build macro: LSQ_PERF_CNT_EN adds perf_ld_cnt_o, perf_st_cnt_o and perf_full_cyc_o.
module lsu_lsq_ooo
  import lsu_lsq_ooo_pkg::*;
#(
  parameter int DEPTH     = LSQ_DEPTH,
  parameter int XLEN      = LSQ_XLEN,
  parameter int ADDR_W    = LSQ_ADDR_W,
  parameter int ROB_IDX_W = LSQ_ROB_IDX_W,
  parameter int PREG_W    = LSQ_PREG_W,
  parameter int ECAUSE_W  = LSQ_ECAUSE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 opcode_i,
  input  logic [1:0]           size_i,
  input  logic                 sign_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [XLEN-1:0]      data_i,
  input  logic [ROB_IDX_W-1:0] rob_index_i,
  input  logic [PREG_W-1:0]    rd_addr_i,
  input  logic                 exc_valid_i,
  input  logic [ECAUSE_W-1:0]  ecause_i,
  lsu_lsq_ooo_if.master        dc,
  output logic                 ls_done_o,
  output logic [ROB_IDX_W-1:0] rob_index_o,
  output logic                 load_data_valid_o,
  output logic [XLEN-1:0]      load_data_o,
  output logic [PREG_W-1:0]    rd_addr_o,
  output logic                 exception_valid_o,
  output logic [ECAUSE_W-1:0]  ecause_o
`ifdef LSQ_PERF_CNT_EN
  ,
  output logic [31:0]          perf_ld_cnt_o,
  output logic [31:0]          perf_st_cnt_o,
  output logic [31:0]          perf_full_cyc_o
`endif
);

  localparam int TAG_W = $clog2(DEPTH);
  localparam logic [TAG_W:0] PTR_ONE   = (TAG_W+1)'(1);
  localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(DEPTH);

  logic [TAG_W:0]         head_q, issue_q, tail_q;
  logic [TAG_W:0]         out_cnt_q, out_cnt_d;
  logic                   drain_q;
  logic [TAG_W-1:0]       head_idx, issue_idx, tail_idx;
  logic [DEPTH-1:0][1:0]  ent_state;
  logic [1:0]             issue_state;
  logic                   iss_opcode, iss_sign;
  logic [1:0]             iss_size;
  logic [ADDR_W-1:0]      iss_addr;
  logic [XLEN-1:0]        iss_data;
  logic                   hd_opcode, hd_exc;
  logic [XLEN-1:0]        hd_data;
  logic [ROB_IDX_W-1:0]   hd_rob;
  logic [PREG_W-1:0]      hd_rd;
  logic [ECAUSE_W-1:0]    hd_ecause;
  logic                   full, alloc_fire, issue_pend, req_fire, issue_skip;
  logic                   ld_fire, resp_hit, retire_fire, ret_ld, ret_exc;

  assign head_idx    = head_q[TAG_W-1:0];
  assign issue_idx   = issue_q[TAG_W-1:0];
  assign tail_idx    = tail_q[TAG_W-1:0];
  assign issue_state = ent_state[issue_idx];

  assign full       = (tail_q - head_q) == DEPTH_CNT;
  assign ready_o    = !full && !drain_q && !flush;
  assign alloc_fire = valid_i && ready_o;

  // The issue pointer trails tail; excepted entries it lands on are stepped over one per cycle.
  assign issue_pend    = issue_q != tail_q;
  assign dc.req_valid  = issue_pend && (issue_state == ST_WAIT_ISSUE) && !flush && !drain_q;
  assign req_fire      = dc.req_valid && dc.req_ready;
  assign issue_skip    = issue_pend && (issue_state == ST_DONE) && !flush;
  assign ld_fire       = req_fire && (iss_opcode == OP_LOAD);
  assign dc.req_opcode = iss_opcode;
  assign dc.req_sign   = iss_sign;
  assign dc.req_size   = iss_size;
  assign dc.req_addr   = iss_addr;
  assign dc.req_data   = iss_data;
  assign dc.req_tag    = issue_idx;
  assign dc.resp_ready = 1'b1;

  assign resp_hit    = dc.resp_valid && !drain_q && (ent_state[dc.resp_tag] == ST_WAIT_RESP);
  assign retire_fire = (head_q != tail_q) && (ent_state[head_idx] == ST_DONE) && !flush;
  assign ret_ld      = retire_fire && (hd_opcode == OP_LOAD) && !hd_exc;
  assign ret_exc     = retire_fire && hd_exc;

  lsq_entry_array #(
    .DEPTH(DEPTH), .XLEN(XLEN), .ADDR_W(ADDR_W), .ROB_IDX_W(ROB_IDX_W),
    .PREG_W(PREG_W), .ECAUSE_W(ECAUSE_W), .TAG_W(TAG_W)
  ) u_entries (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_en(alloc_fire), .alloc_idx(tail_idx), .alloc_opcode(opcode_i),
    .alloc_sign(sign_i), .alloc_size(size_i), .alloc_addr(addr_i), .alloc_data(data_i),
    .alloc_rob(rob_index_i), .alloc_rd(rd_addr_i), .alloc_exc(exc_valid_i),
    .alloc_ecause(ecause_i),
    .issue_en(req_fire), .issue_idx(issue_idx),
    .resp_en(resp_hit), .resp_idx(dc.resp_tag), .resp_data(dc.resp_data),
    .retire_en(retire_fire), .head_idx(head_idx),
    .state(ent_state),
    .iss_opcode(iss_opcode), .iss_sign(iss_sign), .iss_size(iss_size),
    .iss_addr(iss_addr), .iss_data(iss_data),
    .hd_opcode(hd_opcode), .hd_exc(hd_exc), .hd_data(hd_data), .hd_rob(hd_rob),
    .hd_rd(hd_rd), .hd_ecause(hd_ecause)
  );

  // Every response retires one outstanding load, including ones orphaned by a flush.
  always_comb begin
    out_cnt_d = out_cnt_q;
    unique case ({ld_fire, dc.resp_valid})
      2'b10:   out_cnt_d = out_cnt_q + PTR_ONE;
      2'b01:   out_cnt_d = (out_cnt_q == '0) ? out_cnt_q : out_cnt_q - PTR_ONE;
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q    <= '0;
      issue_q   <= '0;
      tail_q    <= '0;
      out_cnt_q <= '0;
      drain_q   <= 1'b0;
    end else begin
      out_cnt_q <= out_cnt_d;
      if (flush) begin
        head_q  <= '0;
        issue_q <= '0;
        tail_q  <= '0;
        drain_q <= out_cnt_d != '0;
      end else begin
        if (alloc_fire)             tail_q  <= tail_q + PTR_ONE;
        if (req_fire || issue_skip) issue_q <= issue_q + PTR_ONE;
        if (retire_fire)            head_q  <= head_q + PTR_ONE;
        if (drain_q && out_cnt_d == '0) drain_q <= 1'b0;
      end
    end
  end

  // Retire stage: one-cycle pulse with the head entry's results, zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ls_done_o         <= 1'b0;
      rob_index_o       <= '0;
      load_data_valid_o <= 1'b0;
      load_data_o       <= '0;
      rd_addr_o         <= '0;
      exception_valid_o <= 1'b0;
      ecause_o          <= '0;
    end else begin
      ls_done_o         <= retire_fire;
      rob_index_o       <= retire_fire ? hd_rob : '0;
      load_data_valid_o <= ret_ld;
      load_data_o       <= ret_ld ? hd_data : '0;
      rd_addr_o         <= ret_ld ? hd_rd : '0;
      exception_valid_o <= ret_exc;
      ecause_o          <= ret_exc ? hd_ecause : '0;
    end
  end

`ifdef LSQ_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ld_cnt_o   <= '0;
      perf_st_cnt_o   <= '0;
      perf_full_cyc_o <= '0;
    end else begin
      if (retire_fire && hd_opcode == OP_LOAD)  perf_ld_cnt_o   <= sat_inc32(perf_ld_cnt_o);
      if (retire_fire && hd_opcode == OP_STORE) perf_st_cnt_o   <= sat_inc32(perf_st_cnt_o);
      if (full && valid_i)                      perf_full_cyc_o <= sat_inc32(perf_full_cyc_o);
    end
  end
`endif

`ifndef SYNTHESIS
  a_resp_tag_waiting: assert property (@(posedge clk) disable iff (rst)
    (dc.resp_valid && !drain_q && !flush) |-> (ent_state[dc.resp_tag] == ST_WAIT_RESP));
`endif

endmodule

// File: tb/tb_lsu_lsq_ooo.sv
// Directed testbench for lsu_lsq_ooo (DEPTH=8); covers the perf counters when LSQ_PERF_CNT_EN is defined.
module tb_lsu_lsq_ooo;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        valid_i;
  logic        ready_o;
  logic        opcode_i;
  logic [1:0]  size_i;
  logic        sign_i;
  logic [38:0] addr_i;
  logic [63:0] data_i;
  logic [5:0]  rob_index_i;
  logic [5:0]  rd_addr_i;
  logic        exc_valid_i;
  logic [3:0]  ecause_i;
  logic        ls_done_o;
  logic [5:0]  rob_index_o;
  logic        load_data_valid_o;
  logic [63:0] load_data_o;
  logic [5:0]  rd_addr_o;
  logic        exception_valid_o;
  logic [3:0]  ecause_o;
`ifdef LSQ_PERF_CNT_EN
  logic [31:0] perf_ld_cnt_o, perf_st_cnt_o, perf_full_cyc_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  lsu_lsq_ooo_if #(.DEPTH(8), .XLEN(64), .ADDR_W(39)) dc ();

  lsu_lsq_ooo #(
    .DEPTH(8), .XLEN(64), .ADDR_W(39), .ROB_IDX_W(6), .PREG_W(6), .ECAUSE_W(4)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_i(valid_i), .ready_o(ready_o),
    .opcode_i(opcode_i), .size_i(size_i), .sign_i(sign_i), .addr_i(addr_i),
    .data_i(data_i), .rob_index_i(rob_index_i), .rd_addr_i(rd_addr_i),
    .exc_valid_i(exc_valid_i), .ecause_i(ecause_i), .dc(dc),
    .ls_done_o(ls_done_o), .rob_index_o(rob_index_o),
    .load_data_valid_o(load_data_valid_o), .load_data_o(load_data_o),
    .rd_addr_o(rd_addr_o), .exception_valid_o(exception_valid_o), .ecause_o(ecause_o)
`ifdef LSQ_PERF_CNT_EN
    ,
    .perf_ld_cnt_o(perf_ld_cnt_o), .perf_st_cnt_o(perf_st_cnt_o),
    .perf_full_cyc_o(perf_full_cyc_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    flush          = 1'b0;
    valid_i        = 1'b0;
    opcode_i       = 1'b0;
    size_i         = 2'd0;
    sign_i         = 1'b0;
    addr_i         = '0;
    data_i         = '0;
    rob_index_i    = '0;
    rd_addr_i      = '0;
    exc_valid_i    = 1'b0;
    ecause_i       = '0;
    dc.resp_valid  = 1'b0;
    dc.resp_tag    = '0;
    dc.resp_data   = '0;
  endtask

  task automatic alloc(input logic op, input logic [38:0] a, input logic [63:0] d,
                       input logic [5:0] rob, input logic [5:0] rd,
                       input logic exc, input logic [3:0] ec);
    valid_i     = 1'b1;
    opcode_i    = op;
    size_i      = 2'd3;
    sign_i      = 1'b1;
    addr_i      = a;
    data_i      = d;
    rob_index_i = rob;
    rd_addr_i   = rd;
    exc_valid_i = exc;
    ecause_i    = ec;
  endtask

  task automatic resp(input logic [2:0] tag, input logic [63:0] d);
    dc.resp_valid = 1'b1;
    dc.resp_tag   = tag;
    dc.resp_data  = d;
  endtask

  task automatic do_reset();
    clr();
    dc.req_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    do_reset();

    // reset state
    #1;
    check("rst_ready",     64'(ready_o), 64'd1);
    check("rst_req_valid", 64'(dc.req_valid), 64'd0);
    check("rst_ls_done",   64'(ls_done_o), 64'd0);
    check("rst_load_data", 64'(load_data_o), 64'd0);
    check("rst_exc",       64'(exception_valid_o), 64'd0);
    check("rst_resp_rdy",  64'(dc.resp_ready), 64'd1);
    step();

    // single store: req at T+1, retire at T+3
    alloc(1'b1, 39'h100, 64'hAB, 6'd5, 6'd0, 1'b0, 4'd0);
    dc.req_ready = 1'b1;
    #1;
    check("st_ready_T0", 64'(ready_o), 64'd1);
    check("st_reqv_T0",  64'(dc.req_valid), 64'd0);
    step(); clr(); #1;
    check("st_reqv_T1", 64'(dc.req_valid), 64'd1);
    check("st_tag_T1",  64'(dc.req_tag), 64'd0);
    check("st_op_T1",   64'(dc.req_opcode), 64'd1);
    check("st_addr_T1", 64'(dc.req_addr), 64'h100);
    check("st_data_T1", dc.req_data, 64'hAB);
    check("st_size_T1", 64'(dc.req_size), 64'd3);
    step(); #1;
    check("st_done_T2", 64'(ls_done_o), 64'd0);
    check("st_reqv_T2", 64'(dc.req_valid), 64'd0);
    step(); #1;
    check("st_done_T3", 64'(ls_done_o), 64'd1);
    check("st_rob_T3",  64'(rob_index_o), 64'd5);
    check("st_ldv_T3",  64'(load_data_valid_o), 64'd0);
    check("st_exc_T3",  64'(exception_valid_o), 64'd0);
    step(); #1;
    check("st_done_T4", 64'(ls_done_o), 64'd0);

    // two loads, responses out of order, in-order retire
    do_reset();
    dc.req_ready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      clr();
      case (c)
        0: alloc(1'b0, 39'h200, 64'd0, 6'd1, 6'd10, 1'b0, 4'd0);
        1: alloc(1'b0, 39'h208, 64'd0, 6'd2, 6'd11, 1'b0, 4'd0);
        5: resp(3'd1, 64'h1111);
        8: resp(3'd0, 64'h2222);
        default: ;
      endcase
      #1;
      if (c == 1) begin
        check("ld_reqv_c1", 64'(dc.req_valid), 64'd1);
        check("ld_tag_c1",  64'(dc.req_tag), 64'd0);
        check("ld_addr_c1", 64'(dc.req_addr), 64'h200);
        check("ld_sign_c1", 64'(dc.req_sign), 64'd1);
      end
      if (c == 2) check("ld_tag_c2", 64'(dc.req_tag), 64'd1);
      if (c == 3) check("ld_reqv_c3", 64'(dc.req_valid), 64'd0);
      if (c == 7) check("ld_done_c7", 64'(ls_done_o), 64'd0);
      if (c == 9) check("ld_done_c9", 64'(ls_done_o), 64'd0);
      if (c == 10) begin
        check("ld_done_c10", 64'(ls_done_o), 64'd1);
        check("ld_rob_c10",  64'(rob_index_o), 64'd1);
        check("ld_ldv_c10",  64'(load_data_valid_o), 64'd1);
        check("ld_data_c10", load_data_o, 64'h2222);
        check("ld_rd_c10",   64'(rd_addr_o), 64'd10);
      end
      if (c == 11) begin
        check("ld_done_c11", 64'(ls_done_o), 64'd1);
        check("ld_rob_c11",  64'(rob_index_o), 64'd2);
        check("ld_data_c11", load_data_o, 64'h1111);
        check("ld_rd_c11",   64'(rd_addr_o), 64'd11);
      end
      if (c == 12) check("ld_done_c12", 64'(ls_done_o), 64'd0);
      step();
    end

    // fill all 8 entries, then one retire frees a slot
    do_reset();
    for (int c = 0; c < 11; c++) begin
      clr();
      if (c <= 8) alloc(1'b1, 39'(c), 64'(c), 6'(c), 6'd0, 1'b0, 4'd0);
      dc.req_ready = (c == 8);
      #1;
      if (c < 8)  check("full_ready_lt8", 64'(ready_o), 64'd1);
      if (c == 5) check("full_hold_tag", 64'(dc.req_tag), 64'd0);
      if (c == 5) check("full_hold_reqv", 64'(dc.req_valid), 64'd1);
      if (c == 8) check("full_ready_c8", 64'(ready_o), 64'd0);
      if (c == 9) check("full_ready_c9", 64'(ready_o), 64'd0);
      if (c == 10) begin
        check("full_ready_c10", 64'(ready_o), 64'd1);
        check("full_done_c10",  64'(ls_done_o), 64'd1);
        check("full_rob_c10",   64'(rob_index_o), 64'd0);
`ifdef LSQ_PERF_CNT_EN
        check("perf_full_cyc", 64'(perf_full_cyc_o), 64'd1);
`endif
      end
      step();
    end

    // excepting alloc: no request, exception retire at T+2; following store is issued
    do_reset();
    dc.req_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      clr();
      if (c == 0) alloc(1'b0, 39'h280, 64'd0, 6'd7, 6'd3, 1'b1, 4'd4);
      if (c == 1) alloc(1'b1, 39'h300, 64'h55, 6'd8, 6'd0, 1'b0, 4'd0);
      #1;
      if (c == 1) check("exc_reqv_c1", 64'(dc.req_valid), 64'd0);
      if (c == 2) begin
        check("exc_done_c2",  64'(ls_done_o), 64'd1);
        check("exc_valid_c2", 64'(exception_valid_o), 64'd1);
        check("exc_cause_c2", 64'(ecause_o), 64'd4);
        check("exc_rob_c2",   64'(rob_index_o), 64'd7);
        check("exc_ldv_c2",   64'(load_data_valid_o), 64'd0);
        check("exc_reqv_c2",  64'(dc.req_valid), 64'd1);
        check("exc_tag_c2",   64'(dc.req_tag), 64'd1);
      end
      if (c == 3) check("exc_done_c3", 64'(ls_done_o), 64'd0);
      if (c == 4) begin
        check("exc_done_c4",  64'(ls_done_o), 64'd1);
        check("exc_valid_c4", 64'(exception_valid_o), 64'd0);
        check("exc_rob_c4",   64'(rob_index_o), 64'd8);
      end
      step();
    end

    // flush with three loads in flight: drain, then resume at tag 0
    do_reset();
    dc.req_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      clr();
      if (c <= 2)  alloc(1'b0, 39'(12'h400 + 8 * c), 64'd0, 6'(20 + c), 6'(c), 1'b0, 4'd0);
      if (c == 4)  flush = 1'b1;
      if (c == 5)  resp(3'd0, 64'hDEAD);
      if (c == 6)  resp(3'd1, 64'hBEEF);
      if (c == 8)  resp(3'd2, 64'hCAFE);
      if (c == 10) alloc(1'b1, 39'h500, 64'h77, 6'd30, 6'd0, 1'b0, 4'd0);
      #1;
      if (c == 3) check("fl_tag_c3", 64'(dc.req_tag), 64'd2);
      if (c >= 4 && c <= 8) check("fl_ready_drain", 64'(ready_o), 64'd0);
      if (c >= 4 && c <= 10) check("fl_no_done", 64'(ls_done_o), 64'd0);
      if (c == 5) check("fl_reqv_c5", 64'(dc.req_valid), 64'd0);
      if (c == 9) check("fl_ready_c9", 64'(ready_o), 64'd1);
      if (c == 11) begin
        check("fl_reqv_c11", 64'(dc.req_valid), 64'd1);
        check("fl_tag_c11",  64'(dc.req_tag), 64'd0);
      end
      step();
    end

`ifdef LSQ_PERF_CNT_EN
    // 3 loads and 2 stores retired
    do_reset();
    dc.req_ready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      clr();
      if (c <= 4) alloc(c[0], 39'(12'h600 + 8 * c), 64'(c), 6'(c), 6'(c), 1'b0, 4'd0);
      if (c == 3) resp(3'd0, 64'h10);
      if (c == 5) resp(3'd2, 64'h12);
      if (c == 7) resp(3'd4, 64'h14);
      #1;
      step();
    end
    check("perf_ld_cnt",     64'(perf_ld_cnt_o), 64'd3);
    check("perf_st_cnt",     64'(perf_st_cnt_o), 64'd2);
    check("perf_full_cyc_0", 64'(perf_full_cyc_o), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
